div32_seq: RTL and testbench

Multi-cycle 32-bit unsigned restoring divider for the ALU. It computes quotient and remainder one bit per clock by reusing the 32-bit ripple-carry adder (RCA32) in subtract mode. This is the iterative inverse of the adder's accumulate path. It sits beside the combinational ALU datapath, and the ALU control stalls on `busy` for DIV/REM operations.

---
 rtl/div32_seq_pkg.sv | 23 ++
 rtl/div32_seq_rca32.sv | 32 +++
 rtl/div32_seq.sv | 127 ++++++++++++
 tb/tb_div32_seq.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/div32_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div32_seq_pkg
// Description : Shared ALU constants: divider FSM encoding, DIV/REM opcodes,
//               divide-by-zero quotient.
// Revision    : 1.0 - initial release
// ============================================================================
package div32_seq_pkg;

    localparam int unsigned C_DATA_W = 32;

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_RUN  = 2'd1;
    localparam logic [1:0] C_ST_DONE = 2'd2;

    localparam logic [3:0] C_ALU_OP_DIV = 4'hC;
    localparam logic [3:0] C_ALU_OP_REM = 4'hD;

    localparam logic [31:0] C_DIV_ZERO_QUOT = 32'hFFFF_FFFF;
    localparam logic [5:0]  C_LAST_ITER     = 6'd31;

endpackage : div32_seq_pkg
`default_nettype wire

// File: rtl/div32_seq_rca32.sv
`default_nettype none
// ============================================================================
// Module      : div32_seq_rca32
// Description : 32-bit ripple-carry adder; cin=1 selects subtract (a - b).
// Revision    : 1.0 - initial release
// ============================================================================
module div32_seq_rca32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    // cin doubles as the subtract select: a + ~b + 1 when set.
    logic [31:0] w_b_eff;
    logic [32:0] w_carry;

    assign w_b_eff    = b ^ {32{cin}};
    assign w_carry[0] = cin;

    generate
        for (genvar i = 0; i < 32; i++) begin : g_bit
            assign sum[i]       = a[i] ^ w_b_eff[i] ^ w_carry[i];
            assign w_carry[i+1] = (a[i] & w_b_eff[i]) | (w_carry[i] & (a[i] ^ w_b_eff[i]));
        end
    endgenerate

    assign cout = w_carry[32];

endmodule : div32_seq_rca32
`default_nettype wire

// File: rtl/div32_seq.sv
`default_nettype none
// ============================================================================
// Module      : div32_seq
// Description : 32-bit unsigned restoring divider, one quotient bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module div32_seq
    import div32_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_zero
);

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [31:0] r_rem;
    logic [31:0] r_q;
    logic [31:0] r_div;
    logic [5:0]  r_cnt;

    logic [32:0] w_shifted;
    logic [31:0] w_diff;
    logic        w_cout;
    logic        w_q_bit;
    logic [31:0] w_rem_next;
    logic [31:0] w_q_next;
    logic        w_accept;
    logic        w_div_is_zero;
    logic        w_last;

    assign w_shifted     = {r_rem, r_q[31]};
    assign w_accept      = start && ((r_state == C_ST_IDLE) || (r_state == C_ST_DONE));
    assign w_div_is_zero = (divisor == 32'd0);
    assign w_last        = (r_cnt == C_LAST_ITER);

    div32_seq_rca32 u_rca32 (
        .a    (w_shifted[31:0]),
        .b    (r_div),
        .cin  (1'b1),
        .sum  (w_diff),
        .cout (w_cout)
    );

    // A set bit 32 means shifted >= D regardless of the 32-bit borrow.
    assign w_q_bit    = w_shifted[32] | w_cout;
    assign w_rem_next = w_q_bit ? w_diff : w_shifted[31:0];
    assign w_q_next   = {r_q[30:0], w_q_bit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= C_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            C_ST_IDLE, C_ST_DONE: begin
                if (w_accept) begin
                    w_state_next = w_div_is_zero ? C_ST_DONE : C_ST_RUN;
                end else begin
                    w_state_next = C_ST_IDLE;
                end
            end
            C_ST_RUN: begin
                if (w_last) begin
                    w_state_next = C_ST_DONE;
                end
            end
            default: w_state_next = C_ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            C_ST_RUN:  busy = 1'b1;
            C_ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem     <= 32'd0;
            r_q       <= 32'd0;
            r_div     <= 32'd0;
            r_cnt     <= 6'd0;
            quotient  <= 32'd0;
            remainder <= 32'd0;
            div_zero  <= 1'b0;
        end else if (w_accept) begin
            if (w_div_is_zero) begin
                quotient  <= C_DIV_ZERO_QUOT;
                remainder <= dividend;
                div_zero  <= 1'b1;
            end else begin
                r_rem    <= 32'd0;
                r_q      <= dividend;
                r_div    <= divisor;
                r_cnt    <= 6'd0;
                div_zero <= 1'b0;
            end
        end else if (r_state == C_ST_RUN) begin
            r_rem <= w_rem_next;
            r_q   <= w_q_next;
            r_cnt <= r_cnt + 6'd1;
            if (w_last) begin
                quotient  <= w_q_next;
                remainder <= w_rem_next;
            end
        end
    end

endmodule : div32_seq
`default_nettype wire

// File: tb/tb_div32_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_div32_seq
// Description : Scoreboard-driven self-checking bench for div32_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div32_seq;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    div32_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    // Drive one request through its accepting edge and push the expected result.
    task automatic issue(input logic [31:0] dd, input logic [31:0] dv, input bit hold);
        exp_t e;
        if (dv == 32'd0) e = '{q: 32'hFFFF_FFFF, r: dd, dz: 1'b1};
        else             e = '{q: dd / dv, r: dd % dv, dz: 1'b0};
        sb.push_back(e);
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    // Bounded wait for done; lat=0 means no done within the budget.
    task automatic wait_done(output int lat, output int nbusy, output int both);
        lat = 0; nbusy = 0; both = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy && done) both++;
            if (busy) nbusy++;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({busy, done, quotient, remainder, div_zero} !== 67'd0) begin
            n_err++;
            $display("FAIL reset_state got busy=%b done=%b q=%h r=%h dz=%b want all 0",
                     busy, done, quotient, remainder, div_zero);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Operand table covering basic, full-range, small-dividend and MSB paths.
    task automatic test_divide();
        logic [31:0] dd_t [5];
        logic [31:0] dv_t [5];
        int lat, nb, both;
        exp_t e;
        dd_t = '{32'd100, 32'hFFFF_FFFF, 32'd3,  32'hFFFF_FFFF, 32'h8000_0000};
        dv_t = '{32'd7,   32'd1,         32'd10, 32'h8000_0000, 32'hFFFF_FFFF};
        for (int i = 0; i < 5; i++) begin
            issue(dd_t[i], dv_t[i], 1'b0);
            wait_done(lat, nb, both);
            e = sb.pop_front();
            n_vec++;
            if (lat != 33 || nb != 32 || both != 0) begin
                n_err++;
                $display("FAIL div_timing[%0d] got lat=%0d busy=%0d overlap=%0d want 33/32/0",
                         i, lat, nb, both);
            end
            n_vec++;
            if ({quotient, remainder, div_zero} !== {e.q, e.r, e.dz}) begin
                n_err++;
                $display("FAIL div_result[%0d] %h/%h got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                         i, dd_t[i], dv_t[i], quotient, remainder, div_zero, e.q, e.r, e.dz);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat, nb, both;
        exp_t e;
        issue(32'd5, 32'd0, 1'b0);
        wait_done(lat, nb, both);
        e = sb.pop_front();
        n_vec++;
        if (lat != 1 || nb != 0) begin
            n_err++;
            $display("FAIL dz_timing got lat=%0d busy=%0d want 1/0", lat, nb);
        end
        n_vec++;
        if ({quotient, remainder, div_zero} !== {e.q, e.r, e.dz}) begin
            n_err++;
            $display("FAIL dz_result got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                     quotient, remainder, div_zero, e.q, e.r, e.dz);
        end
        issue(32'd9, 32'd3, 1'b0);
        wait_done(lat, nb, both);
        e = sb.pop_front();
        n_vec++;
        if (lat != 33 || {quotient, remainder, div_zero} !== {e.q, e.r, e.dz}) begin
            n_err++;
            $display("FAIL after_dz got lat=%0d q=%h r=%h dz=%b want 33 q=%h r=%h dz=%b",
                     lat, quotient, remainder, div_zero, e.q, e.r, e.dz);
        end
    endtask

    task automatic test_run_ignored();
        int lat, nb, both;
        exp_t e;
        issue(32'd1000, 32'd9, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            start    = ~start;
            dividend = $urandom;
            divisor  = (k == 2) ? 32'd0 : $urandom;
        end
        start = 1'b0;
        wait_done(lat, nb, both);
        e = sb.pop_front();
        n_vec++;
        if (lat != 27 || {quotient, remainder, div_zero} !== {e.q, e.r, e.dz}) begin
            n_err++;
            $display("FAIL run_ignored got lat=%0d q=%h r=%h dz=%b want 27 q=%h r=%h dz=%b",
                     lat, quotient, remainder, div_zero, e.q, e.r, e.dz);
        end
    endtask

    task automatic test_back_to_back();
        int lat, nb, both;
        exp_t e;
        issue(32'd50, 32'd5, 1'b1);
        dividend = 32'd77;
        divisor  = 32'd4;
        wait_done(lat, nb, both);
        e = sb.pop_front();
        n_vec++;
        if (lat != 33 || {quotient, remainder, div_zero} !== {e.q, e.r, e.dz}) begin
            n_err++;
            $display("FAIL b2b_first got lat=%0d q=%h r=%h want 33 q=%h r=%h",
                     lat, quotient, remainder, e.q, e.r);
        end
        // start is still high in DONE, so this edge launches 77/4.
        sb.push_back('{q: 32'd19, r: 32'd1, dz: 1'b0});
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, nb, both);
        e = sb.pop_front();
        n_vec++;
        if (lat != 33 || nb != 32 || {quotient, remainder, div_zero} !== {e.q, e.r, e.dz}) begin
            n_err++;
            $display("FAIL b2b_second got lat=%0d busy=%0d q=%h r=%h want 33/32 q=%h r=%h",
                     lat, nb, quotient, remainder, e.q, e.r);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, nb, both;
        exp_t e;
        issue(32'd100, 32'd7, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        void'(sb.pop_back());
        n_vec++;
        if ({busy, done, quotient, remainder, div_zero} !== 67'd0) begin
            n_err++;
            $display("FAIL mid_run_reset got busy=%b done=%b q=%h r=%h dz=%b want all 0",
                     busy, done, quotient, remainder, div_zero);
        end
        @(negedge clk);
        rst = 1'b0;
        issue(32'd100, 32'd7, 1'b0);
        wait_done(lat, nb, both);
        e = sb.pop_front();
        n_vec++;
        if (lat != 33 || {quotient, remainder, div_zero} !== {e.q, e.r, e.dz}) begin
            n_err++;
            $display("FAIL after_reset got lat=%0d q=%h r=%h dz=%b want 33 q=%h r=%h dz=%b",
                     lat, quotient, remainder, div_zero, e.q, e.r, e.dz);
        end
    endtask

    initial begin
        test_reset();
        test_divide();
        test_div_zero();
        test_run_ignored();
        test_back_to_back();
        test_reset_mid_run();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain got %0d entries want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_div32_seq
`default_nettype wire
